// File: rtl/alu_pkg.sv
// Shared opcode encodings and channel indices for the ALU front-end loader.
package alu_pkg;

    typedef enum logic [5:0] {
        OP_ADD = 6'b100000,
        OP_SUB = 6'b100010,
        OP_AND = 6'b100100,
        OP_OR  = 6'b100101,
        OP_XOR = 6'b100110,
        OP_SRA = 6'b000011,
        OP_SRL = 6'b000010,
        OP_NOR = 6'b100111
    } alu_op_e;

    localparam alu_op_e OP_RESET = OP_ADD;

    localparam int unsigned IDX_A  = 0;
    localparam int unsigned IDX_B  = 1;
    localparam int unsigned IDX_OP = 2;
    localparam int unsigned N_CH   = 3;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stable-count debouncer, rising-edge strobe.
module btn_debounce #(
    parameter int unsigned DB_COUNT = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_rise
);

    localparam int unsigned CW = $clog2(DB_COUNT + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          stable_prev_q, stable_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Stable only flips after DB_COUNT+1 consecutive disagreeing samples.
    always_comb begin
        sync1_d       = btn_raw;
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        cnt_d         = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DB_COUNT)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
        end
    end

    assign btn_rise = stable_q & ~stable_prev_q;

endmodule

// File: rtl/alu_input_loader.sv
// Loads the switch bank into ALU operand A, operand B or opcode on debounced button presses.
module alu_input_loader
    import alu_pkg::*;
#(
    parameter int unsigned N_BITS   = 6,
    parameter int unsigned N_OPS    = 6,
    parameter int unsigned DB_COUNT = 1000000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [N_BITS-1:0] Switches,
    input  logic              Btn_A,
    input  logic              Btn_B,
    input  logic              Btn_Op,
    output logic [N_BITS-1:0] Data_A,
    output logic [N_BITS-1:0] Data_B,
    output logic [N_OPS-1:0]  Op,
    output logic [2:0]        Loaded,
    output logic              Load_Pulse
);

    if (N_OPS > N_BITS) begin : g_bad_ops
        $error("alu_input_loader: N_OPS must not exceed N_BITS");
    end
    if (DB_COUNT < 1) begin : g_bad_db
        $error("alu_input_loader: DB_COUNT must be at least 1");
    end

    logic [N_CH-1:0]   btn_raw;
    logic [N_CH-1:0]   rise;
    logic [N_BITS-1:0] data_a_q, data_a_d;
    logic [N_BITS-1:0] data_b_q, data_b_d;
    logic [N_OPS-1:0]  op_q, op_d;
    logic [N_CH-1:0]   loaded_q, loaded_d;
    logic              load_pulse_q, load_pulse_d;

    assign btn_raw[IDX_A]  = Btn_A;
    assign btn_raw[IDX_B]  = Btn_B;
    assign btn_raw[IDX_OP] = Btn_Op;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .clock    (clock),
            .reset_n  (reset_n),
            .btn_raw  (btn_raw[i]),
            .btn_rise (rise[i])
        );
    end

    always_comb begin
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        op_d         = op_q;
        if (rise[IDX_A])  data_a_d = Switches;
        if (rise[IDX_B])  data_b_d = Switches;
        if (rise[IDX_OP]) op_d     = Switches[N_OPS-1:0];
        loaded_d     = loaded_q | rise;
        load_pulse_d = |rise;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_a_q     <= '0;
            data_b_q     <= '0;
            op_q         <= N_OPS'(OP_RESET);
            loaded_q     <= '0;
            load_pulse_q <= 1'b0;
        end else begin
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            op_q         <= op_d;
            loaded_q     <= loaded_d;
            load_pulse_q <= load_pulse_d;
        end
    end

    assign Data_A     = data_a_q;
    assign Data_B     = data_b_q;
    assign Op         = op_q;
    assign Loaded     = loaded_q;
    assign Load_Pulse = load_pulse_q;

endmodule
